ysyx_22050550_regfile_mp: RTL and testbench

// - Parametrised multi-port integer register file with built-in scoreboard, successor to the single-write GPR/CSR bank.
// - Sits between IDU (read + destination allocate) and WBU (write-back + busy clear); lets a pipelined core detect RAW hazards and forward same-cycle write-back data.
// - Register 0 is hardwired zero; CSRs remain outside this block.

---
 rtl/ysyx_22050550_regfile_mp.sv | 95 +++++++++
 tb/tb_ysyx_22050550_regfile_mp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050550_regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Register 0 reads as zero. Optional same-cycle forwarding of write data and busy clears.
module ysyx_22050550_regfile_mp #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*XLEN-1:0]  wdata,
    input  logic [NWR-1:0]       wclr,
    input  logic                 flush,
    output logic [AW:0]          busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] wval [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] clr_hit;
    logic [AW:0]     cnt_next;
    logic [AW-1:0]   ra [NRD];

    // Per-register merge of all write ports; later ports overwrite earlier ones.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wval[r]    = regs[r];
            clr_hit[r] = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (r != 0 && wen[j] && waddr[j*AW +: AW] == AW'(r)) begin
                    wval[r]    = wdata[j*XLEN +: XLEN];
                    clr_hit[r] = clr_hit[r] | wclr[j];
                end
            end
        end
    end

    // Busy next-state: flush beats a new allocation, which beats a clear.
    always_comb begin
        busy_next = '0;
        cnt_next  = '0;
        for (int r = 1; r < NREG; r++) begin
            if (flush)
                busy_next[r] = 1'b0;
            else if (alloc_en && alloc_addr == AW'(r))
                busy_next[r] = 1'b1;
            else if (clr_hit[r])
                busy_next[r] = 1'b0;
            else
                busy_next[r] = busy[r];
            cnt_next = cnt_next + {{AW{1'b0}}, busy_next[r]};
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra[i] = raddr[i*AW +: AW];
            if (!reset && ra[i] != '0) begin
                if (BYPASS != 0) begin
                    rdata[i*XLEN +: XLEN] = wval[ra[i]];
                    rbusy[i] = busy[ra[i]]
                             & ~(clr_hit[ra[i]] & ~(alloc_en && alloc_addr == ra[i]));
                end else begin
                    rdata[i*XLEN +: XLEN] = regs[ra[i]];
                    rbusy[i] = busy[ra[i]];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) regs[r] <= wval[r];
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_ysyx_22050550_regfile_mp.sv
// Scoreboard bench: bypass and non-bypass instances share one stimulus stream and one reference model.
module tb_ysyx_22050550_regfile_mp;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [9:0]   raddr;
    logic [127:0] rdata_a, rdata_b;
    logic [1:0]   rbusy_a, rbusy_b;
    logic         alloc_en;
    logic [4:0]   alloc_addr;
    logic [1:0]   wen;
    logic [9:0]   waddr;
    logic [127:0] wdata;
    logic [1:0]   wclr;
    logic         flush;
    logic [5:0]   cnt_a, cnt_b;

    int tests = 0;
    int fails = 0;

    ysyx_22050550_regfile_mp #(.BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wclr(wclr), .flush(flush), .busy_cnt(cnt_a));

    ysyx_22050550_regfile_mp #(.BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wclr(wclr), .flush(flush), .busy_cnt(cnt_b));

    always #5 clock = ~clock;

    typedef struct {
        string        name;
        logic [127:0] rd_a, rd_b;
        logic [1:0]   rb_a, rb_b;
        logic [5:0]   cnt;
    } exp_t;
    exp_t sbq[$];

    logic [63:0] m_reg  [32];
    bit          m_busy [32];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 0;
        end
    endfunction

    // Architectural view of what port i should show this cycle.
    function automatic void model_read(input bit byp, output logic [127:0] rd, output logic [1:0] rb);
        rd = '0;
        rb = '0;
        for (int i = 0; i < 2; i++) begin
            logic [4:0]  a;
            logic [63:0] d;
            bit          b, clr;
            a = raddr[i*5 +: 5];
            d = '0;
            b = 0;
            clr = 0;
            if (!reset && a != 0) begin
                d = m_reg[a];
                b = m_busy[a];
                if (byp) begin
                    for (int j = 0; j < 2; j++)
                        if (wen[j] && waddr[j*5 +: 5] == a) begin
                            d = wdata[j*64 +: 64];
                            if (wclr[j]) clr = 1;
                        end
                    if (clr && !(alloc_en && alloc_addr == a)) b = 0;
                end
            end
            rd[i*64 +: 64] = d;
            rb[i] = b;
        end
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    function automatic void model_edge();
        bit clr_set [32];
        for (int r = 0; r < 32; r++) clr_set[r] = 0;
        for (int j = 0; j < 2; j++) begin
            logic [4:0] a;
            a = waddr[j*5 +: 5];
            if (wen[j] && a != 0) begin
                m_reg[a] = wdata[j*64 +: 64];
                if (wclr[j]) clr_set[a] = 1;
            end
        end
        for (int r = 1; r < 32; r++) begin
            if (flush) m_busy[r] = 0;
            else if (alloc_en && alloc_addr == 5'(r)) m_busy[r] = 1;
            else if (clr_set[r]) m_busy[r] = 0;
        end
    endfunction

    function automatic void push_expect(string nm);
        exp_t e;
        e.name = nm;
        model_read(1, e.rd_a, e.rb_a);
        model_read(0, e.rd_b, e.rb_b);
        e.cnt = reset ? 6'd0 : 6'(model_count());
        sbq.push_back(e);
    endfunction

    always @(negedge clock) begin
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.name, ".rdata_a0"}, rdata_a[63:0],   e.rd_a[63:0]);
            chk({e.name, ".rdata_a1"}, rdata_a[127:64], e.rd_a[127:64]);
            chk({e.name, ".rdata_b0"}, rdata_b[63:0],   e.rd_b[63:0]);
            chk({e.name, ".rdata_b1"}, rdata_b[127:64], e.rd_b[127:64]);
            chk({e.name, ".rbusy_a"},  64'(rbusy_a),    64'(e.rb_a));
            chk({e.name, ".rbusy_b"},  64'(rbusy_b),    64'(e.rb_b));
            chk({e.name, ".cnt_a"},    64'(cnt_a),      64'(e.cnt));
            chk({e.name, ".cnt_b"},    64'(cnt_b),      64'(e.cnt));
        end
    end

    task automatic idle();
        raddr = '0; alloc_en = 0; alloc_addr = '0; wen = '0;
        waddr = '0; wdata = '0; wclr = '0; flush = 0;
    endtask

    task automatic wr(int p, logic [4:0] a, logic [63:0] d, bit c);
        wen[p] = 1'b1;
        waddr[p*5 +: 5] = a;
        wdata[p*64 +: 64] = d;
        wclr[p] = c;
    endtask

    task automatic rd(logic [4:0] a0, logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic alloc(logic [4:0] a);
        alloc_en = 1'b1;
        alloc_addr = a;
    endtask

    task automatic step(string nm);
        push_expect(nm);
        @(negedge clock);
        @(posedge clock);
        if (!reset) model_edge();
        #1;
        idle();
    endtask

    // Reset raised between edges: outputs must clear before any clock edge.
    task automatic async_reset(string nm);
        reset = 1'b1;
        push_expect(nm);
        @(negedge clock);
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        model_clear();
        rd(5, 0);
        push_expect("reset_init");
        @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        wr(0, 5, 64'hDEAD_BEEF, 0); rd(5, 0);      step("wr_x5_same");
        rd(5, 0); wr(1, 0, 64'h1234, 0);           step("rd_x5_wr_x0");
        rd(0, 5);                                  step("rd_x0");

        wr(0, 7, 64'h11, 0); wr(1, 7, 64'h22, 0); rd(7, 5); step("conflict_same");
        rd(7, 7);                                  step("conflict_after");

        alloc(3); rd(3, 0);                        step("alloc_x3");
        rd(3, 5);                                  step("x3_busy");
        wr(0, 3, 64'h99, 1); rd(3, 0);             step("clr_x3");
        rd(3, 0);                                  step("x3_free");

        alloc(4); rd(4, 0);                        step("alloc_x4");
        alloc(4); wr(1, 4, 64'h44, 1); rd(4, 4);   step("alloc_clr_x4");
        rd(4, 0);                                  step("x4_still_busy");
        wr(0, 4, 64'h45, 1);                       step("clr_x4");

        alloc(1);                                  step("alloc_x1");
        alloc(2);                                  step("alloc_x2");
        alloc(9); rd(1, 2);                        step("alloc_x9");
        rd(1, 9);                                  step("three_busy");
        flush = 1; alloc(10); wr(0, 1, 64'hF1, 1); wr(1, 2, 64'hF2, 0); rd(1, 2); step("flush");
        rd(10, 1);                                 step("after_flush");

        wr(0, 12, 64'hABCD, 0); alloc(13);         step("pre_reset_wr");
        rd(12, 13);                                step("pre_reset_rd");
        wr(0, 12, 64'h5555, 0); rd(12, 7);         async_reset("mid_reset");
        rd(12, 7);                                 step("post_reset");

        for (int k = 0; k < 400; k++) begin
            raddr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            alloc_en   = ($urandom_range(0, 9) < 4);
            alloc_addr = 5'($urandom_range(0, 7));
            wen        = 2'($urandom);
            waddr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wdata      = {$urandom, $urandom, $urandom, $urandom};
            wclr       = 2'($urandom);
            flush      = ($urandom_range(0, 19) == 0);
            if (k == 200) async_reset("rand_reset");
            else step("rand");
        end

        for (int t = 0; t < 10 && sbq.size() > 0; t++) @(posedge clock);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d expected=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
